key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Consumer of the debouncer's output stream: classifies button activity into single-click, double-click, long-press and auto-repeat events.
- Inputs are a one-cycle active-low press pulse and the debounced active-low hold level, both synchronous to clk.
- Outputs are one-cycle active-high event strobes that feed the clock's mode/setting controller.

Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- DBL_WIN_MS, 300, maximum release-to-second-press gap counted as a double click.
- LONG_MS, 1000, hold time for a long press.
- REPEAT_MS, 200, auto-repeat period while held after a long press.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- key_pulse_n  in  1  debounced press strobe; low for one cycle per press.
- key_hold_n  in  1  debounced key level; low while held.
- single_click  out  1  one-cycle strobe.
- double_click  out  1  one-cycle strobe.
- long_press  out  1  one-cycle strobe.
- repeat_tick  out  1  one-cycle strobe during a held long press.
- busy  out  1  high whenever FSM is not in IDLE.

Behaviour:
- Cycle constants are computed as CLK_FREQ/1000*X_MS: DBL_CYC, LONG_CYC, REP_CYC.
- Timer: unsigned, width $clog2 of the largest constant. Cleared on every state transition and on each repeat_tick. Otherwise increments every cycle while not in IDLE.
- Reset (rstn low, asynchronous): state IDLE, timer 0, all outputs 0.
- All outputs are registered. Each strobe is high for exactly one cycle, in the cycle after the edge on which its condition is sampled. busy tracks the registered state.
- IDLE:
  - key_pulse_n==0 -> PRESS1.
  - key_hold_n low without a pulse is ignored; stay in IDLE.
- PRESS1:
  - key_hold_n==1 -> WAIT2. Release has priority over long timeout in the same cycle.
  - Else timer==LONG_CYC-1 -> LONG and assert long_press.
  - key_pulse_n is ignored.
- LONG:
  - key_hold_n==1 -> IDLE. No click is emitted.
  - Else timer==REP_CYC-1 -> assert repeat_tick, clear timer, stay in LONG.
  - Release in the same cycle as a repeat timeout: release wins, no tick.
- WAIT2:
  - key_pulse_n==0 -> PRESS2 and assert double_click. A pulse has priority over timeout in the same cycle.
  - Else timer==DBL_CYC-1 -> IDLE and assert single_click.
- PRESS2:
  - key_hold_n==1 -> IDLE.
  - No long press is generated from a second press, however long it is held.
- Illegal state encoding -> IDLE.
- Strobes are mutually exclusive: at most one is asserted in any cycle.
- Reset asserted mid-event aborts the event silently; no strobe is emitted afterwards.

Decomposition:
- Shared package holds:
  - state encodings: IDLE, PRESS1, WAIT2, PRESS2, LONG;
  - the ms-to-cycles conversion function, so it is reused by the debouncer and the clock divider.
- One sub-module: event_timer, a clearable up-counter with a terminal-compare output, parameterised width.
- FSM and output registers stay in the top module.

Test Plan:
All scenarios use CLK_FREQ=1000 (1 cycle/ms), DBL_WIN_MS=5, LONG_MS=10, REPEAT_MS=3.
- Single click: pulse at t0, hold low 3 cycles then high, no second pulse -> single_click exactly once, 5 cycles after release is sampled. No other strobes.
- Double click: press/release (2 cycles), second pulse 3 cycles after release -> double_click one cycle after the second pulse. Holding the second press 20 cycles then gives no long_press and no single_click.
- Long press with repeat: pulse then hold 20 cycles -> long_press 10 cycles after the pulse, then repeat_tick every 3 cycles (3 ticks). Release -> IDLE, busy low, no click.
- Simultaneous events:
  - second pulse on the same cycle the WAIT2 timer hits 4 -> double_click, not single_click;
  - release on the cycle the PRESS1 timer hits 9 -> no long_press, path continues to single_click.
- Reset mid-operation: rstn low during WAIT2 -> all outputs 0 immediately, busy 0. After release of reset, no strobe appears for 20 cycles.
- Spurious level: key_hold_n low 15 cycles with no pulse in IDLE -> no strobes, busy stays 0.

Source files
------------

// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the button front end: event FSM state encodings and
// helpers that turn millisecond settings into clock-cycle counts.

package key_event_decoder_pkg;

  // Event classifier states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_t;

  // Converts a duration in milliseconds to a number of clock cycles. The
  // divide happens first so that large clock frequencies do not overflow.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return clk_freq / 1000 * ms;
  endfunction

  // Largest of three cycle counts, used to size a shared timer.
  function automatic int unsigned max_of3(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter width able to hold every value below max_value; never narrower
  // than one bit so degenerate settings still elaborate.
  function automatic int unsigned counter_width(input int unsigned max_value);
    if (max_value <= 1) return 1;
    return $clog2(max_value);
  endfunction

endpackage

// File: rtl/key_event_decoder_event_timer.sv
// Clearable up-counter with a compare against a caller-supplied terminal
// value. The event FSM reloads the terminal every state, so one counter
// serves the long-press, repeat and double-click windows.

module event_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count;

  // Count up while enabled; clear wins over counting so the first cycle of a
  // new window always starts from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced button activity into single-click, double-click,
// long-press and auto-repeat strobes for the mode/setting controller.
// All outputs are registered; each strobe lasts exactly one cycle.

module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned DBL_WIN_MS = 300,
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned REPEAT_MS  = 200
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_pulse_n,
  input  logic key_hold_n,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int unsigned DBL_CYC  = ms_to_cycles(CLK_FREQ, DBL_WIN_MS);
  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int unsigned REP_CYC  = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int unsigned MAX_CYC  = max_of3(DBL_CYC, LONG_CYC, REP_CYC);
  localparam int unsigned TIMER_W  = counter_width(MAX_CYC);

  // The timer is compared against "window length minus one": the cycle that
  // samples this value is the last cycle of the window.
  localparam logic [TIMER_W-1:0] DBL_TERM  = TIMER_W'(DBL_CYC - 1);
  localparam logic [TIMER_W-1:0] LONG_TERM = TIMER_W'(LONG_CYC - 1);
  localparam logic [TIMER_W-1:0] REP_TERM  = TIMER_W'(REP_CYC - 1);

  key_state_t         state;
  logic [TIMER_W-1:0] timer_terminal;
  logic               timer_clear;
  logic               timer_enable;
  logic               timer_done;

  assign timer_enable = (state != IDLE);

  // Pick the window that the current state is timing.
  always_comb begin
    timer_terminal = '0;
    case (state)
      PRESS1:  timer_terminal = LONG_TERM;
      LONG:    timer_terminal = REP_TERM;
      WAIT2:   timer_terminal = DBL_TERM;
      default: timer_terminal = '0;
    endcase
  end

  // Restart the timer on every state change and on each repeat tick. In IDLE
  // the timer is held at zero, which also covers the transition out of IDLE.
  always_comb begin
    timer_clear = 1'b0;
    case (state)
      IDLE:    timer_clear = 1'b1;
      PRESS1:  timer_clear = key_hold_n | timer_done;
      LONG:    timer_clear = key_hold_n | timer_done;
      WAIT2:   timer_clear = ~key_pulse_n | timer_done;
      PRESS2:  timer_clear = key_hold_n;
      default: timer_clear = 1'b1;
    endcase
  end

  event_timer #(
    .WIDTH(TIMER_W)
  ) u_event_timer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (timer_clear),
    .enable     (timer_enable),
    .terminal   (timer_terminal),
    .at_terminal(timer_done)
  );

  // Event FSM with registered strobes and busy flag. Strobes default low so
  // each one is a single-cycle pulse, and only one branch can raise one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;

      case (state)
        // A held level with no press strobe is not a new press.
        IDLE: begin
          busy <= 1'b0;
          if (!key_pulse_n) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end

        // Release takes precedence over the long-press timeout.
        PRESS1: begin
          busy <= 1'b1;
          if (key_hold_n) begin
            state <= WAIT2;
          end else if (timer_done) begin
            state      <= LONG;
            long_press <= 1'b1;
          end
        end

        // Release ends the long press silently, even on a repeat boundary.
        LONG: begin
          busy <= 1'b1;
          if (key_hold_n) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer_done) begin
            repeat_tick <= 1'b1;
          end
        end

        // A second press on the last cycle of the window still counts.
        WAIT2: begin
          busy <= 1'b1;
          if (!key_pulse_n) begin
            state        <= PRESS2;
            double_click <= 1'b1;
          end else if (timer_done) begin
            state        <= IDLE;
            single_click <= 1'b1;
            busy         <= 1'b0;
          end
        end

        // The second press never turns into a long press.
        PRESS2: begin
          busy <= 1'b1;
          if (key_hold_n) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder. Each gesture is described by a
// few numbers (first hold length, optional gap and second hold length); the
// expected strobe and busy timeline is derived from those numbers with plain
// arithmetic, then the DUT is driven cycle by cycle and compared.

module tb_key_event_decoder;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned DBL_WIN_MS = 5;
  localparam int unsigned LONG_MS    = 10;
  localparam int unsigned REPEAT_MS  = 3;

  localparam int DBL_CYC  = CLK_FREQ / 1000 * DBL_WIN_MS;
  localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
  localparam int REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int MAX_LEN  = 128;

  logic clk;
  logic rstn;
  logic key_pulse_n;
  logic key_hold_n;
  logic single_click;
  logic double_click;
  logic long_press;
  logic repeat_tick;
  logic busy;

  // Per-cycle stimulus and expectations; index c is the cycle whose inputs
  // are sampled on a clock edge, expectations are the outputs after it.
  logic stim_pulse_n [MAX_LEN];
  logic stim_hold_n  [MAX_LEN];
  logic exp_single   [MAX_LEN];
  logic exp_double   [MAX_LEN];
  logic exp_long     [MAX_LEN];
  logic exp_tick     [MAX_LEN];
  logic exp_busy     [MAX_LEN];

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  key_event_decoder #(
    .CLK_FREQ  (CLK_FREQ),
    .DBL_WIN_MS(DBL_WIN_MS),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_pulse_n (key_pulse_n),
    .key_hold_n  (key_hold_n),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic observed, input logic expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_all_low(input string tag);
    check_output({tag, " single"}, single_click, 1'b0);
    check_output({tag, " double"}, double_click, 1'b0);
    check_output({tag, " long"},   long_press,   1'b0);
    check_output({tag, " tick"},   repeat_tick,  1'b0);
    check_output({tag, " busy"},   busy,         1'b0);
  endtask

  task automatic clear_timeline();
    for (int c = 0; c < MAX_LEN; c++) begin
      stim_pulse_n[c] = 1'b1;
      stim_hold_n[c]  = 1'b1;
      exp_single[c]   = 1'b0;
      exp_double[c]   = 1'b0;
      exp_long[c]     = 1'b0;
      exp_tick[c]     = 1'b0;
      exp_busy[c]     = 1'b0;
    end
  endtask

  // Reference model: a press starting at cycle 0 held low for h1 cycles,
  // optionally followed by a second press gap cycles after the release,
  // held for h2 cycles. Event times follow from the window lengths alone.
  task automatic build_gesture(input int h1, input bit second, input int gap,
                               input int h2, output int len);
    int end_c;
    int p;
    clear_timeline();
    stim_pulse_n[0] = 1'b0;
    for (int c = 0; c < h1; c++) stim_hold_n[c] = 1'b0;
    if (h1 > LONG_CYC) begin
      exp_long[LONG_CYC] = 1'b1;
      for (int t = LONG_CYC + REP_CYC; t < h1; t += REP_CYC) exp_tick[t] = 1'b1;
      end_c = h1;
    end else if (second) begin
      p = h1 + gap;
      stim_pulse_n[p] = 1'b0;
      for (int c = p; c < p + h2; c++) stim_hold_n[c] = 1'b0;
      exp_double[p] = 1'b1;
      end_c = p + h2;
    end else begin
      exp_single[h1 + DBL_CYC] = 1'b1;
      end_c = h1 + DBL_CYC;
    end
    for (int c = 0; c < end_c; c++) exp_busy[c] = 1'b1;
    len = end_c + 3;
  endtask

  // Drive the first n cycles of the timeline and compare after each edge.
  task automatic apply_stimulus(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      key_pulse_n = stim_pulse_n[c];
      key_hold_n  = stim_hold_n[c];
      @(posedge clk);
      #1;
      check_output($sformatf("%s single@%0d", name, c), single_click, exp_single[c]);
      check_output($sformatf("%s double@%0d", name, c), double_click, exp_double[c]);
      check_output($sformatf("%s long@%0d",   name, c), long_press,   exp_long[c]);
      check_output($sformatf("%s tick@%0d",   name, c), repeat_tick,  exp_tick[c]);
      check_output($sformatf("%s busy@%0d",   name, c), busy,         exp_busy[c]);
    end
    key_pulse_n = 1'b1;
    key_hold_n  = 1'b1;
  endtask

  initial begin
    int len;
    int h1;
    int gap;
    int h2;
    bit second;

    key_pulse_n = 1'b1;
    key_hold_n  = 1'b1;
    rstn        = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check_all_low("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_all_low("reset_held");
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single click");
    build_gesture(3, 1'b0, 0, 0, len);
    apply_stimulus("single", len);

    $display("[TB] double click with long second hold");
    build_gesture(2, 1'b1, 3, 20, len);
    apply_stimulus("double", len);

    $display("[TB] long press with repeat");
    build_gesture(20, 1'b0, 0, 0, len);
    apply_stimulus("long", len);

    $display("[TB] second press on last window cycle");
    build_gesture(2, 1'b1, DBL_CYC, 2, len);
    apply_stimulus("dbl_edge", len);

    $display("[TB] release on long-press boundary");
    build_gesture(LONG_CYC, 1'b0, 0, 0, len);
    apply_stimulus("rel_edge", len);

    $display("[TB] held level without press strobe");
    clear_timeline();
    for (int c = 0; c < 15; c++) stim_hold_n[c] = 1'b0;
    apply_stimulus("spurious", 18);

    $display("[TB] reset during double-click window");
    build_gesture(3, 1'b0, 0, 0, len);
    apply_stimulus("pre_reset", 5);
    #2 rstn = 1'b0;
    #1;
    check_all_low("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    clear_timeline();
    apply_stimulus("post_reset", 20);

    $display("[TB] random gestures");
    for (int i = 0; i < 40; i++) begin
      h1     = int'($urandom_range(1, 25));
      second = (h1 <= LONG_CYC) && ($urandom_range(0, 1) == 1);
      gap    = int'($urandom_range(1, DBL_CYC));
      h2     = int'($urandom_range(1, 25));
      build_gesture(h1, second, gap, h2, len);
      apply_stimulus($sformatf("rand%0d", i), len);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
